// File: rtl/seq_detect_param_moore.sv
`default_nettype none
// ============================================================================
// Module  : seq_detect_param_moore
// Brief   : Parametrised Moore serial pattern detector, overlap select,
//           input-valid qualifier and saturating detection counter.
// Rev     : 1.0  initial release
// ============================================================================
module seq_detect_param_moore #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             ovl_en,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] det_count,
   output logic [5:0]       fill_level
);

   if ((PAT_LEN < 2) || (PAT_LEN > 32)) begin : g_bad_pat_len
      $error("seq_detect_param_moore: PAT_LEN must be in 2..32");
   end
   if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
      $error("seq_detect_param_moore: CNT_W must be in 1..32");
   end

   localparam logic [5:0]       c_full    = 6'(PAT_LEN);
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [PAT_LEN-1:0] r_hist;
   logic [5:0]         r_fill;
   logic [5:0]         r_fresh;
   logic               r_out;
   logic [CNT_W-1:0]   r_cnt;

   logic [PAT_LEN-1:0] w_hist_nxt;
   logic [5:0]         w_fill_nxt;
   logic [5:0]         w_fresh_nxt;
   logic               w_match;

   always_comb begin
      w_hist_nxt  = {r_hist[PAT_LEN-2:0], in};
      w_fill_nxt  = (r_fill  == c_full) ? r_fill  : r_fill  + 6'd1;
      w_fresh_nxt = (r_fresh == c_full) ? r_fresh : r_fresh + 6'd1;
      // fresh gates non-overlap mode so bits consumed by a match are not reused
      w_match     = in_valid && (w_hist_nxt == PATTERN) && (w_fill_nxt == c_full)
                    && (ovl_en || (w_fresh_nxt == c_full));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist  <= '0;
         r_fill  <= '0;
         r_fresh <= '0;
         r_out   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_out <= w_match;
         if (in_valid) begin
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_fresh <= w_match ? 6'd0 : w_fresh_nxt;
         end
         if (cnt_clr)
            r_cnt <= w_match ? c_cnt_one : '0;
         else if (w_match && (r_cnt != c_cnt_max))
            r_cnt <= r_cnt + c_cnt_one;
      end
   end

   assign out        = r_out;
   assign det_count  = r_cnt;
   assign fill_level = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param_moore.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detect_param_moore
// Brief   : Directed table-driven bench for seq_detect_param_moore.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_detect_param_moore;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       vld = 1'b0;
   logic       ovl = 1'b0;
   logic       clr = 1'b0;

   logic       out_def,  out_ones,  out_c2;
   logic [7:0] cnt_def,  cnt_ones;
   logic [1:0] cnt_c2;
   logic [5:0] fill_def, fill_ones, fill_c2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_detect_param_moore u_def (
      .clk(clk), .rst(rst), .in(din), .in_valid(vld), .ovl_en(ovl), .cnt_clr(clr),
      .out(out_def), .det_count(cnt_def), .fill_level(fill_def));

   seq_detect_param_moore #(.PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(8)) u_ones (
      .clk(clk), .rst(rst), .in(din), .in_valid(vld), .ovl_en(ovl), .cnt_clr(clr),
      .out(out_ones), .det_count(cnt_ones), .fill_level(fill_ones));

   seq_detect_param_moore #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .in(din), .in_valid(vld), .ovl_en(ovl), .cnt_clr(clr),
      .out(out_c2), .det_count(cnt_c2), .fill_level(fill_c2));

   typedef struct {
      string      name;
      logic       rst, din, vld, ovl, clr;
      logic       eout;
      logic [7:0] ecnt;
      logic [5:0] efill;
   } vec_t;

   vec_t vecs[$];

   task automatic push(input string nm, input logic r, input logic d, input logic v,
                       input logic o, input logic c, input logic eo,
                       input logic [7:0] ec, input logic [5:0] ef);
      vec_t t;
      t.name = nm; t.rst = r; t.din = d; t.vld = v; t.ovl = o; t.clr = c;
      t.eout = eo; t.ecnt = ec; t.efill = ef;
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next.
   task automatic step(input logic r, input logic d, input logic v, input logic o, input logic c);
      rst = r; din = d; vld = v; ovl = o; clr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // test 1: 1010 non-overlap, two separated detections
      push("t1_rst", 1,0,0,0,0, 0,0,0);
      push("t1_b1",  0,1,1,0,0, 0,0,1);
      push("t1_b2",  0,0,1,0,0, 0,0,2);
      push("t1_b3",  0,1,1,0,0, 0,0,3);
      push("t1_b4",  0,0,1,0,0, 1,1,4);
      push("t1_b5",  0,0,1,0,0, 0,1,4);
      push("t1_b6",  0,0,1,0,0, 0,1,4);
      push("t1_b7",  0,1,1,0,0, 0,1,4);
      push("t1_b8",  0,0,1,0,0, 0,1,4);
      push("t1_b9",  0,1,1,0,0, 0,1,4);
      push("t1_b10", 0,0,1,0,0, 1,2,4);
      push("t1_clr", 0,0,0,0,1, 0,0,4);
      // test 2a: 101010 non-overlap
      push("t2a_rst", 1,0,0,0,0, 0,0,0);
      push("t2a_b1",  0,1,1,0,0, 0,0,1);
      push("t2a_b2",  0,0,1,0,0, 0,0,2);
      push("t2a_b3",  0,1,1,0,0, 0,0,3);
      push("t2a_b4",  0,0,1,0,0, 1,1,4);
      push("t2a_b5",  0,1,1,0,0, 0,1,4);
      push("t2a_b6",  0,0,1,0,0, 0,1,4);
      // test 2b: 101010 overlap
      push("t2b_rst", 1,0,0,1,0, 0,0,0);
      push("t2b_b1",  0,1,1,1,0, 0,0,1);
      push("t2b_b2",  0,0,1,1,0, 0,0,2);
      push("t2b_b3",  0,1,1,1,0, 0,0,3);
      push("t2b_b4",  0,0,1,1,0, 1,1,4);
      push("t2b_b5",  0,1,1,1,0, 0,1,4);
      push("t2b_b6",  0,0,1,1,0, 1,2,4);
      // mode change: overlap match clears fresh, then non-overlap cannot reuse it
      push("mc_rst", 1,0,0,1,0, 0,0,0);
      push("mc_b1",  0,1,1,1,0, 0,0,1);
      push("mc_b2",  0,0,1,1,0, 0,0,2);
      push("mc_b3",  0,1,1,1,0, 0,0,3);
      push("mc_b4",  0,0,1,1,0, 1,1,4);
      push("mc_b5",  0,1,1,0,0, 0,1,4);
      push("mc_b6",  0,0,1,0,0, 0,1,4);
      push("mc_b7",  0,1,1,1,0, 0,1,4);
      push("mc_b8",  0,0,1,1,0, 1,2,4);
      // test 4: idle cycles between bits
      push("t4_rst", 1,0,0,0,0, 0,0,0);
      push("t4_b1",  0,1,1,0,0, 0,0,1);
      push("t4_i1",  0,0,0,0,0, 0,0,1);
      push("t4_i2",  0,1,0,0,0, 0,0,1);
      push("t4_b2",  0,0,1,0,0, 0,0,2);
      push("t4_i3",  0,1,0,0,0, 0,0,2);
      push("t4_i4",  0,0,0,0,0, 0,0,2);
      push("t4_b3",  0,1,1,0,0, 0,0,3);
      push("t4_i5",  0,0,0,0,0, 0,0,3);
      push("t4_i6",  0,0,0,0,0, 0,0,3);
      push("t4_b4",  0,0,1,0,0, 1,1,4);
      push("t4_i7",  0,0,0,0,0, 0,1,4);
      push("t4_i8",  0,0,0,0,0, 0,1,4);
      // test 5: reset mid-pattern, rst wins over a valid bit
      push("t5_rst",  1,0,0,0,0, 0,0,0);
      push("t5_b1",   0,1,1,0,0, 0,0,1);
      push("t5_b2",   0,0,1,0,0, 0,0,2);
      push("t5_b3",   0,1,1,0,0, 0,0,3);
      push("t5_rst2", 1,0,1,0,0, 0,0,0);
      push("t5_c1",   0,0,1,0,0, 0,0,1);
      push("t5_c2",   0,1,1,0,0, 0,0,2);
      push("t5_c3",   0,0,1,0,0, 0,0,3);
      push("t5_c4",   0,1,1,0,0, 0,0,4);
      push("t5_c5",   0,0,1,0,0, 1,1,4);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].din, vecs[i].vld, vecs[i].ovl, vecs[i].clr);
         chk({vecs[i].name, "_out"},  {31'd0, out_def},  {31'd0, vecs[i].eout});
         chk({vecs[i].name, "_cnt"},  {24'd0, cnt_def},  {24'd0, vecs[i].ecnt});
         chk({vecs[i].name, "_fill"}, {26'd0, fill_def}, {26'd0, vecs[i].efill});
      end

      // test 3a: 1111 overlap, seven ones
      step(1,0,0,1,0);
      chk("t3a_rst_cnt", {24'd0, cnt_ones}, 32'd0);
      for (int i = 1; i <= 7; i++) begin
         step(0,1,1,1,0);
         chk($sformatf("t3a_b%0d_out", i), {31'd0, out_ones}, (i >= 4) ? 32'd1 : 32'd0);
      end
      chk("t3a_cnt", {24'd0, cnt_ones}, 32'd4);

      // test 3b: 1111 non-overlap, seven ones
      step(1,0,0,0,0);
      for (int i = 1; i <= 7; i++) begin
         step(0,1,1,0,0);
         chk($sformatf("t3b_b%0d_out", i), {31'd0, out_ones}, (i == 4) ? 32'd1 : 32'd0);
      end
      chk("t3b_cnt", {24'd0, cnt_ones}, 32'd1);

      // test 6: 2-bit counter saturation and clear interaction
      step(1,0,0,1,0);
      chk("t6_rst_cnt", {30'd0, cnt_c2}, 32'd0);
      step(0,1,1,1,0);
      step(0,0,1,1,0);
      for (int d = 1; d <= 6; d++) begin
         step(0,1,1,1,0);
         chk($sformatf("t6_d%0d_lo_out", d), {31'd0, out_c2}, 32'd0);
         step(0,0,1,1,0);
         chk($sformatf("t6_d%0d_out", d), {31'd0, out_c2}, 32'd1);
         chk($sformatf("t6_d%0d_cnt", d), {30'd0, cnt_c2}, (d < 3) ? 32'(d) : 32'd3);
      end
      step(0,1,1,1,0);
      step(0,0,1,1,1);
      chk("t6_clr_match_out", {31'd0, out_c2}, 32'd1);
      chk("t6_clr_match_cnt", {30'd0, cnt_c2}, 32'd1);
      step(0,0,0,1,1);
      chk("t6_clr_only_out", {31'd0, out_c2}, 32'd0);
      chk("t6_clr_only_cnt", {30'd0, cnt_c2}, 32'd0);
      chk("t6_clr_only_fill", {26'd0, fill_c2}, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_detect_param_moore.md
Name: seq_detect_param_moore

Overview:
Parametrised Moore-type serial bit-sequence detector. It is the generalised successor of the fixed 4-bit 1010 detector. The pattern and its length are set by parameters. Overlap or non-overlap matching is selected at run time. The block adds an input-valid qualifier and a saturating detection counter. It sits on a 1-bit serial stream and flags each completed pattern to downstream control logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32; elaboration error outside this range.
PATTERN, 4'b1010, pattern value, PAT_LEN bits wide; PATTERN[PAT_LEN-1] is the first bit received.
CNT_W, 8, width of the detection counter; legal range 1..32.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in  input  1  serial data bit.
in_valid  input  1  when 1, `in` is accepted this cycle; when 0, the cycle is ignored.
ovl_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled per accepted bit.
cnt_clr  input  1  synchronous clear of det_count.
out  output  1  Moore detect flag, registered.
det_count  output  CNT_W  saturating count of detections.
fill_level  output  6  debug: accepted bits since last reset, saturating at PAT_LEN.

Behaviour:
- Reset, when rst=1 at a rising edge:
  - out=0, det_count=0, fill_level=0.
  - History shift register is all zeros; fresh count=0.
  - rst has priority over all other inputs.
  - A pattern in progress when reset occurs is discarded; no detection can use pre-reset bits.
- Accepted bit (in_valid=1):
  - The bit shifts into a PAT_LEN-bit history register; the newest bit goes to the LSB.
  - filled (= fill_level) increments, saturating at PAT_LEN.
  - fresh increments, saturating at PAT_LEN. fresh counts accepted bits since reset or since the last detection.
- Match condition, evaluated on the updated history of an accepted bit:
  - history == PATTERN, AND
  - filled == PAT_LEN, AND
  - ovl_en=1, or fresh == PAT_LEN.
- On a match:
  - The registered detect state is set, so out=1 in the cycle after the completing bit is sampled.
  - fresh is cleared to 0 in both modes, so switching from overlap to non-overlap never reuses bits of a prior match.
- out behaviour:
  - out=1 for exactly one clock per match.
  - out returns to 0 on the next edge unless that edge also completes a match.
  - Consecutive matches on back-to-back accepted bits hold out=1 continuously. This is only possible with ovl_en=1 and a self-overlapping pattern, e.g. 1111.
  - A cycle with in_valid=0 leaves history, filled and fresh unchanged, and out goes to 0.
- Mode change: a change of ovl_en takes effect for the next accepted bit. History is not flushed.
- det_count:
  - Increments by 1 on each match, saturating at 2^CNT_W-1.
  - If cnt_clr=1 in the same cycle as a match, det_count becomes 1; the detection is not lost.
  - cnt_clr alone sets det_count to 0.
  - cnt_clr has no effect on the detector state.
- Moore property: out depends only on registered state. There is no combinational path from in, in_valid or ovl_en to out.
- Latency: 1 clock from the edge sampling the completing bit to out=1.

Test Plan:
1. Defaults, ovl_en=0, stream 1,0,1,0,0,0,1,0,1,0 with in_valid=1 every cycle:
   - out pulses one cycle after bit 4 and one cycle after bit 10.
   - det_count ends at 2.
2. Defaults, stream 1,0,1,0,1,0:
   - ovl_en=0: one pulse (after bit 4); det_count=1.
   - ovl_en=1: pulses after bits 4 and 6; det_count=2.
3. PATTERN=4'b1111, ovl_en=1, seven consecutive 1s:
   - out high for 4 consecutive cycles (after bits 4..7); det_count=4.
   - Repeat with ovl_en=0: single pulse after bit 4; det_count=1.
4. Defaults, bits 1,0,1,0 with in_valid=0 for 2 cycles between each bit:
   - Exactly one out pulse, in the cycle after the final 0 is accepted.
   - No pulse during the idle cycles.
5. Defaults, rst=1 asserted for one cycle after bits 1,0,1, then bits 0,1,0,1,0:
   - No pulse for the post-reset leading 0.
   - Pulse after the 1,0,1,0 that follows; det_count=1.
6. CNT_W=2, six detections:
   - det_count saturates at 3.
   - cnt_clr coincident with the 7th detection gives det_count=1.
   - cnt_clr alone gives det_count=0.
